clk_div_multi: RTL and testbench

Parametrised multi-channel programmable clock divider; successor to the fixed free-running counter tap divider. Each channel produces a one-cycle clock-enable tick and a near-50% divided square wave from the system clock, with a runtime-programmable divisor. Divisors are loaded over a valid/ready config port, applied glitch-free at period boundaries, and a sync input phase-aligns all channels. Sits between the 100 MHz board clock and display/scan/debounce logic.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_chan.sv | 100 ++++++++++
 rtl/clk_div_multi.sv | 84 ++++++++
 tb/tb_clk_div_multi.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable multi-channel clock divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clk_div_pkg;

    // Smallest divisor that still yields a square wave (one high, one low cycle).
    localparam int MIN_DIV     = 2;
    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_CNT_W   = 28;
    localparam int DEF_DIV_VAL = 100000000;

    // Channel-select width; never narrower than one bit so a single-channel
    // build still has a legal cfg_ch port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, tick and square-wave outputs.
// Latency: tick/div_out registered, one cycle after the counting edge they describe.
// Backpressure: o_pending high while a reload waits for a period boundary; the top
//               refuses further loads for this channel until it drops.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   i_en          count enable for this channel
//   i_sync        phase-align: restart the period, apply any waiting divisor
//   i_load        accepted, validated divisor request for this channel
//   i_div         requested divisor
//   o_tick        one-cycle pulse once per divisor period
//   o_div_out     divided square wave (high floor(N/2), low ceil(N/2))
//   o_pending     a reload is queued for the next wrap
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_div_out,
    output logic             o_pending
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_shadow;
    logic             r_pending;
    logic             r_tick;
    logic             r_div_out;

    logic             w_last;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_hi;

    assign w_last     = (r_cnt == (r_div_act - CNT_W'(1)));
    assign w_cnt_next = w_last ? '0 : (r_cnt + CNT_W'(1));
    // High for the last floor(N/2) counts of the period, so the falling edge
    // lines up with the tick (count wraps to zero).
    assign w_hi       = (w_cnt_next >= (r_div_act - (r_div_act >> 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_div_act    <= CNT_W'(DEF_DIV);
            r_div_shadow <= CNT_W'(DEF_DIV);
            r_pending    <= 1'b0;
            r_tick       <= 1'b0;
            r_div_out    <= 1'b0;
        end else if (i_sync) begin
            // Restart from phase zero; a load on this same edge wins over a
            // queued one since it is the newer request.
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_div_out <= 1'b0;
            r_pending <= 1'b0;
            if (i_load) begin
                r_div_act <= i_div;
            end else if (r_pending) begin
                r_div_act <= r_div_shadow;
            end
        end else if (i_load && !i_en) begin
            // Idle channel: no period in flight, so take the divisor at once.
            r_div_act <= i_div;
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_div_out <= 1'b0;
        end else begin
            if (i_en) begin
                r_cnt     <= w_cnt_next;
                r_tick    <= w_last;
                r_div_out <= w_hi;
                if (w_last && r_pending) begin
                    r_div_act <= r_div_shadow;
                    r_pending <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
            end
            // Loads only arrive while nothing is pending, so this never races
            // the wrap-apply above; a wrap on this edge still uses the old N.
            if (i_load) begin
                r_div_shadow <= i_div;
                r_pending    <= 1'b1;
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_div_out = r_div_out;
    assign o_pending = r_pending;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor reload.
// Latency: tick/div_out one cycle after the counting edge; cfg_err one cycle after accept.
// Backpressure: cfg_ready low only while the addressed channel has a reload queued.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   en[NUM_CH]           per-channel count enable
//   sync                 phase-align all channels
//   cfg_valid/cfg_ready  divisor request handshake (cfg_ready is combinational)
//   cfg_ch, cfg_div      target channel and requested divisor
//   cfg_err              one-cycle pulse: last accepted request was rejected
//   tick[NUM_CH]         one-cycle enable per divisor period
//   div_out[NUM_CH]      divided square waves
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH  = DEF_NUM_CH,
    parameter  int CNT_W   = DEF_CNT_W,
    parameter  int DEF_DIV = DEF_DIV_VAL,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_out
);

    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_load;
    logic              w_ch_ok;
    logic              w_div_ok;
    logic              w_accept;
    logic              w_good;
    logic              r_cfg_err;

    // One-hot channel decode; an out-of-range cfg_ch decodes to all zeros,
    // which makes it both always-ready and a rejected request.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_sel
        assign w_sel[g] = (cfg_ch == CH_W'(g));
    end

    assign w_ch_ok   = |w_sel;
    assign w_div_ok  = (cfg_div >= CNT_W'(MIN_DIV));
    assign cfg_ready = ~|(w_sel & w_pending);
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_good    = w_accept && w_ch_ok && w_div_ok;
    assign w_load    = w_good ? w_sel : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && !(w_ch_ok && w_div_ok);
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_en      (en[g]),
            .i_sync    (sync),
            .i_load    (w_load[g]),
            .i_div     (cfg_div),
            .o_tick    (tick[g]),
            .o_div_out (div_out[g]),
            .o_pending (w_pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: vector table plus hand sequences.
// Three channels are built so that cfg_ch=3 is out of range; channel 2 stays
// disabled throughout and must remain silent.
module tb_clk_div_multi;

    localparam int NCH = 3;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           sync;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_err;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] div_out;

    always #5 clk = ~clk;

    clk_div_multi #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DEF_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .div_out   (div_out)
    );

    typedef struct {
        bit         chk;
        logic       rst;
        logic [2:0] en;
        logic       sync;
        logic       v;
        logic [1:0] ch;
        logic [7:0] div;
        logic       rdy;
        logic [2:0] t;
        logic [2:0] o;
        logic       e;
    } vec_t;

    typedef struct {
        bit         chk;
        int         id;
        logic [2:0] t;
        logic [2:0] o;
        logic       e;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   vid    = 0;

    function automatic vec_t mk(bit c, logic r, logic [2:0] e_n, logic s, logic v,
                                logic [1:0] ch, logic [7:0] d, logic rdy,
                                logic [2:0] t, logic [2:0] o, logic e);
        vec_t x;
        x.chk = c; x.rst = r; x.en = e_n; x.sync = s; x.v = v; x.ch = ch;
        x.div = d; x.rdy = rdy; x.t = t; x.o = o; x.e = e;
        return x;
    endfunction

    // Closed-form channel behaviour: k enabled edges after count c0 with divisor n.
    // Returns {tick, div_out}.
    function automatic logic [1:0] pat(int n, int c0, int k);
        int c;
        c = (c0 + k) % n;
        return {(c == 0), (c >= n - n / 2)};
    endfunction

    // Both ch0 and ch1 counting freely, no config request.
    function automatic vec_t run_v(int n0, int c0, int n1, int c1, int k,
                                   logic [1:0] ch, logic rdy);
        logic [1:0] p0;
        logic [1:0] p1;
        p0 = pat(n0, c0, k);
        p1 = pat(n1, c1, k);
        return mk(1, 0, 3'b011, 0, 0, ch, 8'd0, rdy,
                  {1'b0, p1[1], p0[1]}, {1'b0, p1[0], p0[0]}, 0);
    endfunction

    task automatic chk(input string nm, input int id, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got %0h expected %0h", nm, id, act, exp);
    endtask

    task automatic apply(input vec_t v);
        exp_t x;
        exp_t y;
        rst       = v.rst;
        en        = v.en;
        sync      = v.sync;
        cfg_valid = v.v;
        cfg_ch    = v.ch;
        cfg_div   = v.div;
        #1;
        if (v.chk) chk("cfg_ready", vid, {7'd0, cfg_ready}, {7'd0, v.rdy});
        x.chk = v.chk; x.id = vid; x.t = v.t; x.o = v.o; x.e = v.e;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        if (y.chk) begin
            chk("tick",    y.id, {5'd0, tick},    {5'd0, y.t});
            chk("div_out", y.id, {5'd0, div_out}, {5'd0, y.o});
            chk("cfg_err", y.id, {7'd0, cfg_err}, {7'd0, y.e});
        end
        vid++;
    endtask

    initial begin
        // ---------------- vector table ----------------
        // Reset with en high and a config request: reset wins, outputs stay 0.
        repeat (2) vecs.push_back(mk(1, 1, 3'b011, 0, 1, 2'd0, 8'd9, 1, 3'b000, 3'b000, 0));
        // Default N=4 on both channels: ticks at edges 4, 8, 12.
        for (int k = 1; k <= 12; k++) vecs.push_back(run_v(4, 0, 4, 0, k, 2'd0, 1));
        // Idle ch0 takes N=5 immediately; ch1 keeps running.
        vecs.push_back(mk(1, 0, 3'b010, 0, 1, 2'd0, 8'd5, 1, 3'b000, 3'b000, 0));
        for (int k = 1; k <= 10; k++) vecs.push_back(run_v(5, 0, 4, 1, k, 2'd0, 1));
        // Live reload of ch1 (N=6) on its wrap edge: old N still used next period.
        vecs.push_back(mk(1, 0, 3'b011, 0, 1, 2'd1, 8'd6, 1, 3'b010, 3'b000, 0));
        // Second request (N=3) stalls until the N=6 reload is applied.
        vecs.push_back(mk(1, 0, 3'b011, 0, 1, 2'd1, 8'd3, 0, 3'b000, 3'b000, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 1, 2'd1, 8'd3, 0, 3'b000, 3'b011, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 1, 2'd1, 8'd3, 0, 3'b000, 3'b011, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 1, 2'd1, 8'd3, 0, 3'b011, 3'b000, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 1, 2'd1, 8'd3, 1, 3'b000, 3'b000, 0));
        // ch1 now runs one N=6 period with N=3 queued.
        vecs.push_back(mk(1, 0, 3'b011, 0, 0, 2'd1, 8'd0, 0, 3'b000, 3'b000, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 0, 2'd1, 8'd0, 0, 3'b000, 3'b011, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 0, 2'd1, 8'd0, 0, 3'b000, 3'b011, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 0, 2'd1, 8'd0, 0, 3'b001, 3'b010, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 0, 2'd1, 8'd0, 0, 3'b010, 3'b000, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 0, 2'd1, 8'd0, 1, 3'b000, 3'b000, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 0, 2'd1, 8'd0, 1, 3'b000, 3'b011, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 0, 2'd1, 8'd0, 1, 3'b010, 3'b001, 0));
        // Errors: divisor 1, then channel 3 (out of range); neither changes state.
        vecs.push_back(mk(1, 0, 3'b011, 0, 1, 2'd0, 8'd1, 1, 3'b001, 3'b000, 1));
        vecs.push_back(mk(1, 0, 3'b011, 0, 1, 2'd3, 8'd7, 1, 3'b000, 3'b010, 1));
        vecs.push_back(mk(1, 0, 3'b011, 0, 0, 2'd0, 8'd0, 1, 3'b010, 3'b000, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 0, 2'd0, 8'd0, 1, 3'b000, 3'b001, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 0, 2'd0, 8'd0, 1, 3'b000, 3'b011, 0));
        vecs.push_back(mk(1, 0, 3'b011, 0, 0, 2'd0, 8'd0, 1, 3'b011, 3'b000, 0));

        rst = 1'b1; en = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // ---------------- sync / enable ----------------
        apply(mk(1, 0, 3'b010, 0, 1, 2'd0, 8'd4, 1, 3'b000, 3'b000, 0));
        apply(mk(1, 0, 3'b001, 0, 1, 2'd1, 8'd8, 1, 3'b000, 3'b000, 0));
        repeat ($urandom_range(1, 11))
            apply(mk(0, 0, 3'b011, 0, 0, 2'd0, 8'd0, 1, 3'b000, 3'b000, 0));
        apply(mk(1, 0, 3'b011, 1, 0, 2'd0, 8'd0, 1, 3'b000, 3'b000, 0));
        for (int k = 1; k <= 16; k++) apply(run_v(4, 0, 8, 0, k, 2'd0, 1));
        // ch0 paused three cycles: holds, no tick, ch1 keeps counting.
        for (int k = 1; k <= 3; k++) begin
            logic [1:0] p1;
            p1 = pat(8, 0, k);
            apply(mk(1, 0, 3'b010, 0, 0, 2'd0, 8'd0, 1,
                     {1'b0, p1[1], 1'b0}, {1'b0, p1[0], 1'b0}, 0));
        end
        for (int k = 1; k <= 8; k++) apply(run_v(4, 0, 8, 3, k, 2'd0, 1));

        // Queued reload on ch1 forced in by sync.
        apply(mk(1, 0, 3'b011, 0, 1, 2'd1, 8'd6, 1, 3'b000, 3'b010, 0));
        apply(mk(1, 0, 3'b011, 1, 0, 2'd1, 8'd0, 0, 3'b000, 3'b000, 0));
        for (int k = 1; k <= 12; k++) apply(run_v(4, 0, 6, 0, k, 2'd1, 1));

        // ---------------- reset with a pending load ----------------
        apply(mk(1, 0, 3'b011, 0, 1, 2'd1, 8'd5, 1, 3'b000, 3'b000, 0));
        apply(mk(1, 1, 3'b011, 0, 0, 2'd1, 8'd0, 0, 3'b000, 3'b000, 0));
        for (int k = 1; k <= 8; k++) apply(run_v(4, 0, 4, 0, k, 2'd1, 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
